mult_arbiter: RTL and testbench
===============================

# mult_arbiter

Round-robin arbiter and issue sequencer that shares one pipelined integer multiplier (`intMult`, fixed 3-cycle latency, one operation per cycle) between `NUM_REQ` requesters. It accepts one operand pair per cycle, registers it onto the multiplier inputs, and tracks each operation's owner through a tag pipeline aligned to the multiplier latency. It returns the product to the owning requester with a one-hot response strobe. It sits between the key-generation datapath clients and the multiplier instance, and also provides a drain handshake so the controller can quiesce the multiplier.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `DATA_WIDTH`, default `` `DATA_SIZE_ARB ``: operand width.
- `MULT_LATENCY`, default 3: cycles from stable `mult_a`/`mult_b` to valid `mult_c`. Must equal the multiplier's pipeline depth.
- `clk`, in, 1: single clock; all state updates on rising edge.
- `reset`, in, 1: synchronous, active-high.
- `req_valid`, in, `NUM_REQ`: per-requester operand-pair valid.
- `req_ready`, out, `NUM_REQ`: per-requester accept. At most one bit is set.
- `req_a`, in, `NUM_REQ*DATA_WIDTH`: packed operand A. Requester i occupies slice `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `req_b`, in, `NUM_REQ*DATA_WIDTH`: packed operand B, same packing as `req_a`.
- `rsp_valid`, out, `NUM_REQ`: one-hot product strobe to the owning requester.
- `rsp_data`, out, `2*DATA_WIDTH`: product, shared by all requesters.
- `mult_a`, out, `DATA_WIDTH`: registered operand A to the multiplier.
- `mult_b`, out, `DATA_WIDTH`: registered operand B to the multiplier.
- `mult_c`, in, `2*DATA_WIDTH`: multiplier product.
- `drain_req`, in, 1: request to stop issuing and empty the pipeline.
- `drain_done`, out, 1: high while in DRAINED.
- `busy`, out, 1: high when any operation is in flight.

## Operation
- Handshake:
  - Transfer on requester i occurs in a cycle where `req_valid[i] & req_ready[i]`.
  - `req_ready` is combinational from `req_valid`, the round-robin pointer and the FSM state.
  - Requesters hold `req_valid`, `req_a` and `req_b` stable until the transfer.
- Arbitration:
  - Grant goes to the first asserted `req_valid` at or after pointer `rr_ptr`, searching upward with wrap-around.
  - On a transfer, `rr_ptr` ← granted index + 1, with modulo wrap from `NUM_REQ`-1 to 0.
  - No transfer → `rr_ptr` unchanged.
- Issue:
  - On a transfer, `mult_a`/`mult_b` register the granted slices.
  - The tag pipeline (valid bit + owner index, depth `MULT_LATENCY`+1) shifts in {1, index}.
  - With no transfer it shifts in {0, x}, and `mult_a`/`mult_b` hold their previous values.
- Response:
  - When the tag pipeline's last stage is valid, the owner's `rsp_valid` bit is 1 and `rsp_data` = `mult_c`.
  - Otherwise `rsp_valid` = 0 and `rsp_data` = 0.
  - Requesters cannot back-pressure responses; they must accept the strobe.
- FSM states:
  - RUN: normal issue. `drain_req` moves to DRAIN.
  - DRAIN: `req_ready` = 0. Moves to DRAINED when the tag pipeline is empty.
  - DRAINED: `req_ready` = 0, `drain_done` = 1. Returns to RUN when `drain_req` deasserts.
- `drain_req` rising in the same cycle as a transfer: the transfer completes and the FSM moves to DRAIN.
- `busy` = OR of all tag-pipeline valid bits.
- Reset, including mid-operation:
  - FSM → RUN, `rr_ptr` → 0, tag pipeline cleared, `mult_a`/`mult_b` → 0.
  - Outputs: `rsp_valid` = 0, `rsp_data` = 0, `drain_done` = 0, `busy` = 0.
  - In-flight products still emerging from the multiplier are discarded and never strobed.
  - The arbiter does not drive the multiplier's own reset.

## Timing
- Transfer in cycle t → `mult_a`/`mult_b` valid in cycle t+1 → `rsp_valid` in cycle t+1+`MULT_LATENCY` (t+4 at default).
- Throughput: one transfer per cycle sustained, with back-to-back responses in transfer order.
- Drain: with the last transfer at t and `drain_req` high, `drain_done` first rises at cycle t+`MULT_LATENCY`+2.
- Starvation bound: a requester holding `req_valid` is granted within `NUM_REQ` cycles in RUN.

## Configuration
- `MULT_ARB_PRIO_EN` defined:
  - Requester 0 has strict priority; whenever `req_valid[0]` = 1 in RUN, it wins regardless of `rr_ptr`.
  - `rr_ptr` does not advance on requester-0 grants.
  - The starvation bound above does not apply to requesters 1..`NUM_REQ`-1.
- `MULT_ARB_PRIO_EN` undefined: pure round-robin as in Operation.

## Structure
- Shared package holds:
  - the FSM state encoding (RUN=2'd0, DRAIN=2'd1, DRAINED=2'd2);
  - the tag struct {valid, owner[$clog2(NUM_REQ)-1:0]};
  - the `MULT_LATENCY` default constant.
- One sub-module, `rr_grant`: combinational round-robin priority search (request vector + pointer → one-hot grant + index).
- Tag pipeline, FSM and operand registers stay in the top module.

## Test plan
- Single op: `reset` then requester 2 sends A=3, B=5 at cycle t → `rsp_valid`=4'b0100, `rsp_data`=15 at t+4; no other strobes.
- All four requesters valid continuously from `rr_ptr`=0 → grants 0,1,2,3,0,… one per cycle; responses in the same order, 4 cycles later, with correct products (A=i+1, B=0x10000 → (i+1)<<16).
- Drain: 3 back-to-back transfers ending at t, `drain_req` asserted at t → `req_ready`=0 from t+1; 3 responses delivered; `drain_done` rises at t+5; clearing `drain_req` restores RUN next cycle.
- Reset mid-flight: 2 transfers at cycles 10 and 11, `reset` at cycle 12 → no `rsp_valid` ever for them; `busy`=0 and `rr_ptr`=0 at cycle 13.
- Wrap-around: only requester 3 valid, then only requester 0 → grants 3 then 0; `rr_ptr` returns to 1.
- With `MULT_ARB_PRIO_EN` defined: requesters 0 and 1 both continuously valid → requester 0 granted every cycle; without the macro, they alternate.

Source files
------------

// File: rtl/mult_arbiter_pkg.sv
// Shared definitions for the multiplier arbiter: FSM state encoding, the
// owner tag carried alongside each multiply, and the default latency.
package mult_arbiter_pkg;

    // Pipeline depth of the shared intMult instance.
    localparam int MULT_LATENCY_DEF = 3;

    // Tag owner field is sized for the largest legal requester count (8),
    // so one struct type serves every NUM_REQ the arbiter can be built with.
    localparam int MAX_NUM_REQ = 8;
    localparam int OWNER_W     = $clog2(MAX_NUM_REQ);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_DRAINED = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic               valid;
        logic [OWNER_W-1:0] owner;
    } tag_t;

    // Round-robin successor with wrap from n-1 back to 0.
    function automatic int next_index(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/mult_arbiter_rr_grant.sv
// Combinational round-robin search: first asserted request at or after
// the pointer, scanning upward with wrap-around. Produces a one-hot grant,
// the granted index and an any-request flag.
module rr_grant #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    logic [IDX_W-1:0]   cand [NUM_REQ];
    logic [NUM_REQ-1:0] hit;

    // Candidate gi is the requester gi positions past the pointer (mod NUM_REQ).
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
        logic [IDX_W:0] sum;
        assign sum       = {1'b0, ptr} + (IDX_W+1)'(gi);
        assign cand[gi]  = (sum >= (IDX_W+1)'(NUM_REQ)) ? IDX_W'(sum - (IDX_W+1)'(NUM_REQ))
                                                        : sum[IDX_W-1:0];
        assign hit[gi]   = req[cand[gi]];
    end

    // Lowest rotated position wins; scanning downward lets it overwrite last.
    always_comb begin
        any = 1'b0;
        idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (hit[k]) begin
                any = 1'b1;
                idx = cand[k];
            end
        end
        grant = any ? (NUM_REQ'(1) << idx) : '0;
    end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbiter and issue sequencer in front of a shared pipelined
// multiplier. Operands are registered onto the multiplier inputs, the owner
// rides a tag pipeline matched to the multiplier latency, and the product is
// strobed back to its owner. A drain handshake lets a controller quiesce it.
// Optional build macro: MULT_ARB_PRIO_EN gives requester 0 strict priority.
`ifndef DATA_SIZE_ARB
`define DATA_SIZE_ARB 32
`endif

module mult_arbiter
    import mult_arbiter_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int DATA_WIDTH   = `DATA_SIZE_ARB,
    parameter int MULT_LATENCY = MULT_LATENCY_DEF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [2*DATA_WIDTH-1:0]       rsp_data,
    output logic [DATA_WIDTH-1:0]         mult_a,
    output logic [DATA_WIDTH-1:0]         mult_b,
    input  logic [2*DATA_WIDTH-1:0]       mult_c,
    input  logic                          drain_req,
    output logic                          drain_done,
    output logic                          busy
);

    localparam int IDX_W = $clog2(NUM_REQ);
    // One extra stage: operand register plus the multiplier's own pipeline.
    localparam int DEPTH = MULT_LATENCY + 1;

    arb_state_t            state_reg;
    logic                  drain_done_reg;
    logic [IDX_W-1:0]      rr_ptr_reg;
    logic [DATA_WIDTH-1:0] mult_a_reg;
    logic [DATA_WIDTH-1:0] mult_b_reg;
    tag_t                  tag_reg [DEPTH];

    logic [DATA_WIDTH-1:0] a_slice [NUM_REQ];
    logic [DATA_WIDTH-1:0] b_slice [NUM_REQ];
    logic [NUM_REQ-1:0]    rr_grant_vec;
    logic [IDX_W-1:0]      rr_idx;
    logic                  rr_any;
    logic [NUM_REQ-1:0]    sel_grant;
    logic [IDX_W-1:0]      sel_idx;
    logic                  sel_any;
    logic                  sel_prio;
    logic                  transfer;
    logic [IDX_W-1:0]      rr_ptr_next;
    logic [DEPTH-1:0]      tag_valid_vec;
    logic                  pipe_filling;

    // Unpack per-requester operand slices.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
        assign a_slice[gi] = req_a[gi*DATA_WIDTH +: DATA_WIDTH];
        assign b_slice[gi] = req_b[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    rr_grant #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_grant (
        .req   (req_valid),
        .ptr   (rr_ptr_reg),
        .grant (rr_grant_vec),
        .idx   (rr_idx),
        .any   (rr_any)
    );

    // Final grant selection: round-robin, optionally overridden by requester 0.
    always_comb begin
        sel_grant = rr_grant_vec;
        sel_idx   = rr_idx;
        sel_any   = rr_any;
        sel_prio  = 1'b0;
`ifdef MULT_ARB_PRIO_EN
        if (req_valid[0]) begin
            sel_grant = NUM_REQ'(1);
            sel_idx   = '0;
            sel_any   = 1'b1;
            sel_prio  = 1'b1;
        end
`endif
    end

    assign transfer    = (state_reg == ST_RUN) && sel_any;
    assign req_ready   = (state_reg == ST_RUN) ? sel_grant : '0;
    assign rr_ptr_next = IDX_W'(next_index(int'(sel_idx), NUM_REQ));

    // Pointer moves past the winner; strict-priority grants leave it alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_reg <= '0;
        end else if (transfer && !sel_prio) begin
            rr_ptr_reg <= rr_ptr_next;
        end
    end

    // Operand registers feed the multiplier; they hold when nothing issues.
    always_ff @(posedge clk) begin
        if (reset) begin
            mult_a_reg <= '0;
            mult_b_reg <= '0;
        end else if (transfer) begin
            mult_a_reg <= a_slice[sel_idx];
            mult_b_reg <= b_slice[sel_idx];
        end
    end

    assign mult_a = mult_a_reg;
    assign mult_b = mult_b_reg;

    // Owner tag pipeline, aligned so the last stage matches mult_c.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                tag_reg[k] <= '0;
            end
        end else begin
            tag_reg[0] <= '{valid: transfer, owner: OWNER_W'(sel_idx)};
            for (int k = 1; k < DEPTH; k++) begin
                tag_reg[k] <= tag_reg[k-1];
            end
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_tag_valid
        assign tag_valid_vec[gi] = tag_reg[gi].valid;
    end

    assign busy = |tag_valid_vec;
    // Anything still short of the output stage; once clear, the pipeline is
    // empty after this edge because nothing new is issued while draining.
    assign pipe_filling = |tag_valid_vec[DEPTH-2:0];

    // Product strobe to the owner of the operation leaving the pipeline.
    always_comb begin
        rsp_valid = '0;
        rsp_data  = '0;
        if (tag_reg[DEPTH-1].valid) begin
            rsp_valid[tag_reg[DEPTH-1].owner[IDX_W-1:0]] = 1'b1;
            rsp_data = mult_c;
        end
    end

    // Drain FSM with registered drain_done.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_RUN;
            drain_done_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_RUN: begin
                    if (drain_req) begin
                        state_reg <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!pipe_filling) begin
                        state_reg      <= ST_DRAINED;
                        drain_done_reg <= 1'b1;
                    end
                end
                ST_DRAINED: begin
                    if (!drain_req) begin
                        state_reg      <= ST_RUN;
                        drain_done_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg      <= ST_RUN;
                    drain_done_reg <= 1'b0;
                end
            endcase
        end
    end

    assign drain_done = drain_done_reg;

endmodule

// File: tb/tb_mult_arbiter.sv
// Randomised scoreboard bench for mult_arbiter. A behavioural model predicts
// grants and pushes expected products; a separate monitor pops them when the
// DUT strobes a response. A 3-stage multiplier model stands in for intMult.
module tb_mult_arbiter;

    localparam int NR  = 4;
    localparam int DW  = 32;
    localparam int LAT = 3;
`ifdef MULT_ARB_PRIO_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*DW-1:0]  req_a;
    logic [NR*DW-1:0]  req_b;
    logic [NR-1:0]     rsp_valid;
    logic [2*DW-1:0]   rsp_data;
    logic [DW-1:0]     mult_a;
    logic [DW-1:0]     mult_b;
    logic [2*DW-1:0]   mult_c;
    logic              drain_req;
    logic              drain_done;
    logic              busy;

    typedef struct {
        int              owner;
        logic [2*DW-1:0] prod;
        int              due;
    } exp_t;

    exp_t            exp_q[$];
    bit              va[NR];
    logic [DW-1:0]   aa[NR];
    logic [DW-1:0]   bb[NR];
    bit              granted[NR];
    int              cyc = 0;
    int              n_checks = 0;
    int              n_err = 0;
    int              m_ptr = 0;
    bit              m_accept = 1'b1;
    logic [2*DW-1:0] mpipe [LAT];

    mult_arbiter #(
        .NUM_REQ      (NR),
        .DATA_WIDTH   (DW),
        .MULT_LATENCY (LAT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .mult_a     (mult_a),
        .mult_b     (mult_b),
        .mult_c     (mult_c),
        .drain_req  (drain_req),
        .drain_done (drain_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Multiplier stand-in: never reset by the arbiter.
    always @(posedge clk) begin
        mpipe[0] <= (2*DW)'(mult_a) * (2*DW)'(mult_b);
        for (int k = 1; k < LAT; k++) mpipe[k] <= mpipe[k-1];
    end
    assign mult_c = mpipe[LAT-1];

    task automatic chk(input string name, input logic [2*DW-1:0] got, input logic [2*DW-1:0] want);
        n_checks++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, got, want);
        end
    endtask

    task automatic pack();
        for (int i = 0; i < NR; i++) begin
            req_valid[i]         = va[i];
            req_a[i*DW +: DW]    = aa[i];
            req_b[i*DW +: DW]    = bb[i];
        end
    endtask

    // Advance one cycle; granted requesters drop valid when drop is set.
    task automatic tick(input bit drop);
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) begin
            if (granted[i]) begin
                granted[i] = 1'b0;
                if (drop) va[i] = 1'b0;
            end
        end
        pack();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        drain_req = 1'b0;
        for (int i = 0; i < NR; i++) begin
            va[i] = 1'b0;
            granted[i] = 1'b0;
        end
        pack();
        exp_q.delete();
        m_ptr = 0;
        m_accept = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Reference model: predicts req_ready and queues the expected product.
    initial begin : model
        int mg;
        logic [NR-1:0] m_exp;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                mg = -1;
                if (m_accept) begin
                    if (PRIO && req_valid[0]) mg = 0;
                    for (int k = 0; k < NR; k++)
                        if (mg < 0 && req_valid[(m_ptr + k) % NR]) mg = (m_ptr + k) % NR;
                end
                m_exp = '0;
                if (mg >= 0) m_exp[mg] = 1'b1;
                chk("req_ready", (2*DW)'(req_ready), (2*DW)'(m_exp));
                if (mg >= 0) begin
                    e.owner = mg;
                    e.prod  = (2*DW)'(aa[mg]) * (2*DW)'(bb[mg]);
                    e.due   = cyc + 1 + LAT;
                    exp_q.push_back(e);
                    granted[mg] = 1'b1;
                    $display("issue cyc=%0d req=%0d a=%0h b=%0h", cyc, mg, aa[mg], bb[mg]);
                    if (!(PRIO && mg == 0)) m_ptr = (mg + 1) % NR;
                end
            end
        end
    end

    // Monitor: compares every response strobe against the scoreboard head.
    initial begin : monitor
        exp_t mon_e;
        logic [NR-1:0] mon_oh;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (rsp_valid != '0 || (exp_q.size() > 0 && exp_q[0].due <= cyc)) begin
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL rsp_unexpected cyc=%0d got rsp_valid=%b want none", cyc, rsp_valid);
                    end else begin
                        mon_e = exp_q.pop_front();
                        mon_oh = '0;
                        mon_oh[mon_e.owner] = 1'b1;
                        if (rsp_valid !== mon_oh || rsp_data !== mon_e.prod || cyc != mon_e.due) begin
                            n_err++;
                            $display("FAIL rsp cyc=%0d got valid=%b data=%0h want valid=%b data=%0h at cyc=%0d",
                                     cyc, rsp_valid, rsp_data, mon_oh, mon_e.prod, mon_e.due);
                        end else begin
                            $display("rsp cyc=%0d owner=%0d data=%0h", cyc, mon_e.owner, rsp_data);
                        end
                    end
                end else begin
                    chk("rsp_idle_data", rsp_data, '0);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog cyc=%0d got no finish want finish", cyc);
        $fatal(1, "timeout");
    end

    initial begin : stim
        int t;
        bit any_v;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        drain_req = 1'b0;
        for (int i = 0; i < NR; i++) begin
            va[i] = 1'b0;
            aa[i] = '0;
            bb[i] = '0;
            granted[i] = 1'b0;
        end

        // Reset state
        do_reset();
        @(negedge clk);
        chk("reset_rsp_valid", (2*DW)'(rsp_valid), '0);
        chk("reset_rsp_data", rsp_data, '0);
        chk("reset_drain_done", (2*DW)'(drain_done), '0);
        chk("reset_busy", (2*DW)'(busy), '0);
        chk("reset_mult_a", (2*DW)'(mult_a), '0);
        chk("reset_mult_b", (2*DW)'(mult_b), '0);

        // Single op: requester 2, 3*5
        tick(1);
        va[2] = 1'b1; aa[2] = 32'd3; bb[2] = 32'd5; pack();
        tick(1);
        @(negedge clk);
        chk("single_mult_a", (2*DW)'(mult_a), 64'd3);
        chk("single_mult_b", (2*DW)'(mult_b), 64'd5);
        chk("single_busy", (2*DW)'(busy), 64'd1);
        tick(1);
        tick(1);
        tick(1);
        @(negedge clk);
        chk("single_rsp_valid", (2*DW)'(rsp_valid), 64'b0100);
        chk("single_rsp_data", rsp_data, 64'd15);
        repeat (3) tick(1);

        // All four continuously valid from rr_ptr=0
        do_reset();
        for (int i = 0; i < NR; i++) begin
            va[i] = 1'b1; aa[i] = DW'(i + 1); bb[i] = 32'h10000;
        end
        pack();
        repeat (8) tick(0);
        for (int i = 0; i < NR; i++) begin
            va[i] = 1'b0; granted[i] = 1'b0;
        end
        pack();
        repeat (6) tick(1);

        // Wrap-around: 3 then 0, then {0,2} probes the pointer
        do_reset();
        va[3] = 1'b1; aa[3] = 32'd21; bb[3] = 32'd3; pack();
        tick(1);
        va[0] = 1'b1; aa[0] = 32'd22; bb[0] = 32'd4; pack();
        tick(1);
        va[0] = 1'b1; aa[0] = 32'd23; bb[0] = 32'd5;
        va[2] = 1'b1; aa[2] = 32'd24; bb[2] = 32'd6; pack();
        tick(1);
        tick(1);
        repeat (6) tick(1);

        // Drain: transfers at t-2, t-1, t with drain_req raised at t
        do_reset();
        for (int i = 0; i < 3; i++) begin
            va[i] = 1'b1; aa[i] = DW'(11 + i); bb[i] = 32'd2;
        end
        pack();
        tick(1);
        tick(1);
        t = cyc;
        drain_req = 1'b1;
        tick(1);                       // t+1
        m_accept = 1'b0;
        va[3] = 1'b1; aa[3] = 32'd7; bb[3] = 32'd9; pack();
        @(negedge clk);
        chk("drain_busy", (2*DW)'(busy), 64'd1);
        tick(1);
        tick(1);
        tick(1);                       // t+4
        @(negedge clk);
        chk("drain_done_early", (2*DW)'(drain_done), '0);
        tick(1);                       // t+5
        @(negedge clk);
        chk("drain_done_rise", (2*DW)'(drain_done), 64'd1);
        chk("drain_idle_busy", (2*DW)'(busy), '0);
        chk("drain_cycle", 64'(cyc - t), 64'd5);
        tick(1);
        tick(1);                       // t+7
        drain_req = 1'b0;
        @(negedge clk);
        chk("drained_hold", (2*DW)'(drain_done), 64'd1);
        tick(1);                       // t+8, back in RUN
        m_accept = 1'b1;
        @(negedge clk);
        chk("drain_exit", (2*DW)'(drain_done), '0);
        repeat (6) tick(1);

        // Reset mid-flight
        do_reset();
        va[1] = 1'b1; aa[1] = 32'd100; bb[1] = 32'd200; pack();
        tick(1);
        va[2] = 1'b1; aa[2] = 32'd300; bb[2] = 32'd400; pack();
        tick(1);
        reset = 1'b1;
        exp_q.delete();
        m_ptr = 0;
        for (int i = 0; i < NR; i++) granted[i] = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("midreset_busy", (2*DW)'(busy), '0);
        chk("midreset_rsp_valid", (2*DW)'(rsp_valid), '0);
        chk("midreset_mult_a", (2*DW)'(mult_a), '0);
        repeat (6) tick(1);
        va[1] = 1'b1; aa[1] = 32'd5; bb[1] = 32'd6;
        va[3] = 1'b1; aa[3] = 32'd7; bb[3] = 32'd8; pack();
        tick(1);
        tick(1);
        repeat (6) tick(1);

        // Requesters 0 and 1 continuously valid
        do_reset();
        va[0] = 1'b1; aa[0] = 32'hABCD; bb[0] = 32'h1234;
        va[1] = 1'b1; aa[1] = 32'h5555; bb[1] = 32'h3; pack();
        repeat (6) tick(0);
        for (int i = 0; i < NR; i++) begin
            va[i] = 1'b0; granted[i] = 1'b0;
        end
        pack();
        repeat (6) tick(1);

        // Randomised traffic
        for (int c = 0; c < 400; c++) begin
            tick(1);
            for (int i = 0; i < NR; i++) begin
                if (!va[i] && $urandom_range(0, 99) < 40) begin
                    va[i] = 1'b1;
                    aa[i] = $urandom;
                    bb[i] = $urandom;
                end
            end
            pack();
        end
        for (int c = 0; c < 60; c++) begin
            any_v = 1'b0;
            for (int i = 0; i < NR; i++) any_v |= va[i];
            if (any_v) tick(1);
        end
        any_v = 1'b0;
        for (int i = 0; i < NR; i++) any_v |= va[i];
        chk("random_all_granted", (2*DW)'(any_v), '0);
        repeat (8) tick(1);
        chk("scoreboard_empty", 64'(exp_q.size()), '0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
